addr_to_data_unit: RTL and testbench

- Cache-line read engine. Given a 64-bit physical address, it wins the shared system bus through the bus arbiter and issues one memory READ.
- It collects the 8-beat (8×64-bit) response into a 512-bit line and presents it with a level `ready` flag.
- It sits between the fetch/translation control FSM in `top` and the main bus, beside the VA→PA walker and the store engine.

---
 rtl/sysbus_pkg.sv | 34 +++
 rtl/addr_to_data_unit.sv | 90 +++++++++
 tb/tb_addr_to_data_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: tag layout, command encodings and the
// read-engine state type used by the bus-side units.
package sysbus_pkg;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
    localparam int         LINE_BYTES    = 64;

    // Tag field layout: [12] dir, [11:8] device, [7:0] id.
    typedef struct packed {
        logic       dir;
        logic [3:0] device;
        logic [7:0] id;
    } sysbus_tag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SEND,
        ST_RESP,
        ST_DONE
    } rd_state_t;

    function automatic sysbus_tag_t make_tag(input logic dir, input logic [3:0] device,
                                             input logic [7:0] id);
        sysbus_tag_t t;
        t.dir    = dir;
        t.device = device;
        t.id     = id;
        return t;
    endfunction

endpackage

// File: rtl/addr_to_data_unit.sv
// Cache-line read engine: wins the system bus, issues one memory READ and
// assembles the 8-beat response into a line presented with a level ready.
module addr_to_data_unit
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int ADDRESS_WIDTH  = 64,
    parameter int LINE_BEATS     = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [ADDRESS_WIDTH-1:0]           addr,
    output logic                               abtr_reqcyc,
    input  logic                               abtr_grant,
    output logic                               bus_busy,
    output logic                               main_bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]          main_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]           main_bus_reqtag,
    input  logic                               main_bus_reqack,
    input  logic                               main_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]          main_bus_resp,
    output logic                               main_bus_respack,
    output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] data,
    output logic                               ready
);

    localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK = ADDRESS_WIDTH'(LINE_BYTES - 1);
    localparam sysbus_tag_t READ_TAG = make_tag(SYSBUS_READ, SYSBUS_MEMORY, 8'h00);

    rd_state_t                  state, state_next;
    logic [BEAT_W-1:0]          beat_cnt;
    logic [ADDRESS_WIDTH-1:0]   line_addr;
    logic                       start;
    logic                       beat_fire;
    logic                       last_beat;

    assign start     = enable && (state == ST_IDLE || state == ST_DONE);
    assign beat_fire = (state == ST_RESP) && main_bus_respcyc;
    assign last_beat = (beat_cnt == BEAT_W'(LINE_BEATS - 1));

    // Bus-facing outputs decode straight from state so an asynchronous reset
    // releases the bus in the same cycle, and are zero when not owning it so
    // sibling units' drivers can be ORed together.
    assign abtr_reqcyc      = (state == ST_ARB) || (state == ST_SEND) || (state == ST_RESP);
    assign bus_busy         = (state == ST_SEND) || (state == ST_RESP);
    assign main_bus_reqcyc  = (state == ST_SEND);
    assign main_bus_req     = (state == ST_SEND) ? BUS_DATA_WIDTH'(line_addr) : '0;
    assign main_bus_reqtag  = (state == ST_SEND) ? BUS_TAG_WIDTH'(READ_TAG) : '0;
    assign main_bus_respack = beat_fire;
    assign ready            = (state == ST_DONE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (enable)                    state_next = ST_ARB;
            ST_ARB:           if (abtr_grant)                state_next = ST_SEND;
            ST_SEND:          if (main_bus_reqack)           state_next = ST_RESP;
            ST_RESP:          if (beat_fire && last_beat)    state_next = ST_DONE;
            default:                                         state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            line_addr <= '0;
            // NOTE: the line register is reset because data must read as
            // zero after reset; it is a flop array, not an inferred RAM.
            data      <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                line_addr <= addr & ~OFFSET_MASK;
                beat_cnt  <= '0;
            end else if (beat_fire) begin
                data[int'(beat_cnt)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= main_bus_resp;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_addr_to_data_unit.sv
// Directed self-checking bench for the cache-line read engine; the arbiter
// grants one cycle after seeing a request, memory acks and streams beats.
module tb_addr_to_data_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [63:0]  addr;
    logic         abtr_reqcyc;
    logic         abtr_grant;
    logic         bus_busy;
    logic         main_bus_reqcyc;
    logic [63:0]  main_bus_req;
    logic [12:0]  main_bus_reqtag;
    logic         main_bus_reqack;
    logic         main_bus_respcyc;
    logic [63:0]  main_bus_resp;
    logic         main_bus_respack;
    logic [511:0] data;
    logic         ready;

    int           checks = 0;
    int           errors = 0;
    logic [511:0] line_model = '0;

    addr_to_data_unit dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .addr             (addr),
        .abtr_reqcyc      (abtr_reqcyc),
        .abtr_grant       (abtr_grant),
        .bus_busy         (bus_busy),
        .main_bus_reqcyc  (main_bus_reqcyc),
        .main_bus_req     (main_bus_req),
        .main_bus_reqtag  (main_bus_reqtag),
        .main_bus_reqack  (main_bus_reqack),
        .main_bus_respcyc (main_bus_respcyc),
        .main_bus_resp    (main_bus_resp),
        .main_bus_respack (main_bus_respack),
        .data             (data),
        .ready            (ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full line read. grant_wait: request cycles before grant rises;
    // ack_wait: SEND cycles before reqack; gap_after: beat index followed by
    // one idle response cycle (-1 for none).
    task automatic run_line(input logic [63:0] a, input int grant_wait, input int ack_wait,
                            input int gap_after, input logic [63:0] seed, input bit poke_enable,
                            output int lat, output logic [63:0] req_seen);
        logic [511:0] prev;
        logic [511:0] exp;
        logic [63:0]  line_a;
        logic [63:0]  v;
        int           n;
        prev   = line_model;
        exp    = prev;
        line_a = {a[63:6], 6'b0};
        req_seen = '0;
        enable = 1'b1; addr = a;
        step();
        enable = 1'b0; addr = '0; lat = 1;
        checks++;
        if (ready !== 1'b0 || abtr_reqcyc !== 1'b1) begin
            errors++; $display("FAIL arb_entry: ready=%b reqcyc=%b expected ready=0 reqcyc=1", ready, abtr_reqcyc);
        end
        n = 0;
        while (bus_busy !== 1'b1 && n < 64) begin
            checks++;
            if (main_bus_reqcyc !== 1'b0 || abtr_reqcyc !== 1'b1) begin
                errors++; $display("FAIL arb_wait: bus_reqcyc=%b abtr_reqcyc=%b expected 0/1", main_bus_reqcyc, abtr_reqcyc);
            end
            n++;
            abtr_grant = (n > grant_wait);
            step(); lat++;
        end
        checks++;
        if (n >= 64) begin
            errors++; $display("FAIL arb_timeout: no bus ownership after %0d cycles expected grant", n);
        end
        for (int k = 0; k <= ack_wait; k++) begin
            checks++;
            if (main_bus_reqcyc !== 1'b1 || main_bus_req !== line_a ||
                main_bus_reqtag !== 13'h1100 || bus_busy !== 1'b1) begin
                errors++;
                $display("FAIL send: reqcyc=%b req=%h tag=%h busy=%b expected 1 %h 1100 1",
                         main_bus_reqcyc, main_bus_req, main_bus_reqtag, bus_busy, line_a);
            end
            req_seen = main_bus_req;
            main_bus_reqack = (k == ack_wait);
            step(); lat++;
        end
        main_bus_reqack = 1'b0;
        checks++;
        if (main_bus_reqcyc !== 1'b0 || main_bus_req !== 64'h0) begin
            errors++; $display("FAIL send_drop: reqcyc=%b req=%h expected 0 0", main_bus_reqcyc, main_bus_req);
        end
        for (int i = 0; i < 8; i++) begin
            if (gap_after >= 0 && i == gap_after + 1) begin
                main_bus_respcyc = 1'b0; main_bus_resp = 64'hbad0_bad0_bad0_bad0;
                #1;
                checks++;
                if (main_bus_respack !== 1'b0 || bus_busy !== 1'b1) begin
                    errors++; $display("FAIL gap: respack=%b busy=%b expected 0 1", main_bus_respack, bus_busy);
                end
                step(); lat++;
            end
            v = seed * 64'(i + 1);
            exp[i*64 +: 64] = v;
            main_bus_respcyc = 1'b1; main_bus_resp = v;
            #1;
            checks++;
            if (main_bus_respack !== 1'b1 || bus_busy !== 1'b1 || abtr_reqcyc !== 1'b1) begin
                errors++;
                $display("FAIL beat%0d: respack=%b busy=%b abtr=%b expected 1 1 1",
                         i, main_bus_respack, bus_busy, abtr_reqcyc);
            end
            if (poke_enable && i == 4) begin
                enable = 1'b1; addr = 64'h5555_0000;
            end
            step(); lat++;
            enable = 1'b0; addr = '0;
            if (i == 0) begin
                checks++;
                if (data[511:64] !== prev[511:64] || data[63:0] !== v) begin
                    errors++; $display("FAIL no_clear: low=%h expected %h, upper beats changed=%b",
                                       data[63:0], v, data[511:64] !== prev[511:64]);
                end
            end
        end
        main_bus_respcyc = 1'b0; main_bus_resp = '0;
        #1;
        abtr_grant = 1'b0;
        checks++;
        if (ready !== 1'b1 || bus_busy !== 1'b0 || abtr_reqcyc !== 1'b0 || main_bus_reqcyc !== 1'b0) begin
            errors++; $display("FAIL done: ready=%b busy=%b abtr=%b reqcyc=%b expected 1 0 0 0",
                               ready, bus_busy, abtr_reqcyc, main_bus_reqcyc);
        end
        checks++;
        if (data !== exp) begin
            errors++; $display("FAIL line: got %h expected %h", data, exp);
        end
        line_model = exp;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; addr = '0; abtr_grant = 1'b0;
        main_bus_reqack = 1'b0; main_bus_respcyc = 1'b0; main_bus_resp = '0;
        step(); step();
        checks++;
        if ({abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack, ready} !== 5'b0 ||
            main_bus_req !== 64'h0 || main_bus_reqtag !== 13'h0 || data !== 512'h0) begin
            errors++; $display("FAIL reset_outputs: flags=%b req=%h tag=%h data_nonzero=%b expected all 0",
                               {abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack, ready},
                               main_bus_req, main_bus_reqtag, data !== 512'h0);
        end
        reset = 1'b1;
        step();
        main_bus_respcyc = 1'b1; main_bus_resp = 64'hdead_beef_dead_beef;
        #1;
        checks++;
        if (main_bus_respack !== 1'b0 || abtr_reqcyc !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL idle_stray: respack=%b abtr=%b ready=%b expected 0 0 0",
                               main_bus_respack, abtr_reqcyc, ready);
        end
        step();
        main_bus_respcyc = 1'b0; main_bus_resp = '0;
        checks++;
        if (data !== 512'h0) begin
            errors++; $display("FAIL idle_stray_data: got %h expected 0", data[63:0]);
        end
    endtask

    task automatic test_basic();
        int lat; logic [63:0] rq;
        run_line(64'h1040, 1, 0, -1, 64'h11, 1'b0, lat, rq);
        checks++;
        if (rq !== 64'h1040) begin errors++; $display("FAIL basic_req: got %h expected 1040", rq); end
        checks++;
        if (data[63:0] !== 64'h11 || data[511:448] !== 64'h88) begin
            errors++; $display("FAIL basic_ends: beat0=%h beat7=%h expected 11 88", data[63:0], data[511:448]);
        end
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL basic_latency: got %0d expected 12", lat); end
    endtask

    task automatic test_unaligned();
        int lat; logic [63:0] rq;
        run_line(64'h107F, 1, 0, -1, 64'h0101_0101_0101_0101, 1'b0, lat, rq);
        checks++;
        if (rq !== 64'h1040) begin errors++; $display("FAIL unaligned_req: got %h expected 1040", rq); end
        checks++;
        if (data[127:64] !== 64'h0202_0202_0202_0202) begin
            errors++; $display("FAIL unaligned_beat1: got %h expected 0202020202020202", data[127:64]);
        end
    endtask

    task automatic test_delayed();
        int lat; logic [63:0] rq;
        run_line(64'h8000_0000_0000_1234, 5, 3, 2, 64'h1000_0000_0000_0003, 1'b0, lat, rq);
        checks++;
        if (rq !== 64'h8000_0000_0000_1200) begin
            errors++; $display("FAIL delayed_req: got %h expected 8000000000001200", rq);
        end
        checks++;
        if (lat !== 20) begin errors++; $display("FAIL delayed_latency: got %0d expected 20", lat); end
        checks++;
        if (data[255:192] !== 64'h4000_0000_0000_000c) begin
            errors++; $display("FAIL delayed_beat3: got %h expected 400000000000000c", data[255:192]);
        end
    endtask

    task automatic test_ignored();
        int lat; logic [63:0] rq;
        run_line(64'h4000, 1, 0, -1, 64'h0000_00ab_0000_0001, 1'b1, lat, rq);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL ignored_latency: got %0d expected 12", lat); end
        for (int c = 0; c < 3; c++) begin
            main_bus_respcyc = 1'b1; main_bus_resp = 64'hffff_0000_ffff_0000;
            #1;
            checks++;
            if (main_bus_respack !== 1'b0 || abtr_reqcyc !== 1'b0 || ready !== 1'b1 ||
                main_bus_reqcyc !== 1'b0) begin
                errors++; $display("FAIL ignored_idle%0d: respack=%b abtr=%b ready=%b reqcyc=%b expected 0 0 1 0",
                                   c, main_bus_respack, abtr_reqcyc, ready, main_bus_reqcyc);
            end
            step();
        end
        main_bus_respcyc = 1'b0; main_bus_resp = '0;
        checks++;
        if (data !== line_model) begin
            errors++; $display("FAIL ignored_data: beat0=%h expected %h", data[63:0], line_model[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] rq;
        run_line(64'h6000, 1, 0, -1, 64'h0000_0000_0000_0777, 1'b0, lat, rq);
        run_line(64'h2000, 1, 0, -1, 64'h0000_0000_0000_1001, 1'b0, lat, rq);
        checks++;
        if (rq !== 64'h2000) begin errors++; $display("FAIL b2b_req: got %h expected 2000", rq); end
        checks++;
        if (data[63:0] !== 64'h1001 || data[511:448] !== 64'h8008) begin
            errors++; $display("FAIL b2b_line: beat0=%h beat7=%h expected 1001 8008", data[63:0], data[511:448]);
        end
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL b2b_latency: got %0d expected 12", lat); end
    endtask

    task automatic test_reset_mid_resp();
        int n;
        enable = 1'b1; addr = 64'h3000;
        step();
        enable = 1'b0; addr = '0;
        n = 0;
        while (bus_busy !== 1'b1 && n < 64) begin
            abtr_grant = abtr_reqcyc;
            step(); n++;
        end
        checks++;
        if (n >= 64) begin errors++; $display("FAIL rst_arb_timeout: no ownership after %0d cycles", n); end
        main_bus_reqack = 1'b1;
        step();
        main_bus_reqack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            main_bus_respcyc = 1'b1; main_bus_resp = 64'h77 + 64'(i);
            step();
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack, ready} !== 5'b0 ||
            main_bus_req !== 64'h0 || main_bus_reqtag !== 13'h0 || data !== 512'h0) begin
            errors++; $display("FAIL rst_mid_resp: flags=%b req=%h data_nonzero=%b expected all 0",
                               {abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack, ready},
                               main_bus_req, data !== 512'h0);
        end
        abtr_grant = 1'b0;
        step();
        checks++;
        if (main_bus_respack !== 1'b0) begin
            errors++; $display("FAIL rst_no_ack: respack=%b expected 0", main_bus_respack);
        end
        reset = 1'b1; main_bus_respcyc = 1'b0; main_bus_resp = '0;
        step();
        checks++;
        if (ready !== 1'b0 || abtr_reqcyc !== 1'b0) begin
            errors++; $display("FAIL rst_release: ready=%b abtr=%b expected 0 0", ready, abtr_reqcyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unaligned();
        test_delayed();
        test_ignored();
        test_back_to_back();
        test_reset_mid_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
